// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//   The ID/EX pipeline register of a classic five-stage RISC pipeline. It also
//   detects load-use hazards. Each cycle the register does one of three things,
//   in this priority order:
//     1. Flush  - a taken branch or jump discards the decode-stage instruction.
//     2. Bubble - a load-use hazard inserts a NOP. The decode instruction stays
//                 upstream because 'stall' freezes the PC and the IF/ID register.
//     3. Load   - the decode-stage instruction moves into EX.
//   A flush or a bubble only zeroes the control bits. The data and specifier
//   fields keep their old values, because nothing downstream uses them when
//   the control bits are zero.
//
// Parameters:
//   DW - datapath width of register operands and immediate
//   RW - register-specifier width
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   id_valid               decode stage holds a real instruction
//   AluOperation_in        decoded ALU operation
//   regDst_in .. DataSrc_in
//                          decoded single-bit control signals
//   readData1_in, readData2_in, imm_in
//                          register-file operands and sign-extended immediate
//   rs_in, rt_in, rd_in    decode-stage register specifiers
//   flush                  taken branch/jump resolved in a later stage
//   *_q                    registered copies presented to EX
//   ex_valid               EX stage holds a real instruction
//   stall                  combinational freeze request for PC and IF/ID
//   bubble_cnt             saturating count of inserted bubbles (flush or hazard)
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          id_valid,
    input  logic [2:0]    AluOperation_in,
    input  logic          regDst_in,
    input  logic          regWrite_in,
    input  logic          AluSrc_in,
    input  logic          MemWrite_in,
    input  logic          MemRead_in,
    input  logic          DataSrc_in,
    input  logic [DW-1:0] readData1_in,
    input  logic [DW-1:0] readData2_in,
    input  logic [DW-1:0] imm_in,
    input  logic [RW-1:0] rs_in,
    input  logic [RW-1:0] rt_in,
    input  logic [RW-1:0] rd_in,
    input  logic          flush,

    output logic [2:0]    AluOperation_q,
    output logic          regDst_q,
    output logic          regWrite_q,
    output logic          AluSrc_q,
    output logic          MemWrite_q,
    output logic          MemRead_q,
    output logic          DataSrc_q,
    output logic [DW-1:0] readData1_q,
    output logic [DW-1:0] readData2_q,
    output logic [DW-1:0] imm_q,
    output logic [RW-1:0] rs_q,
    output logic [RW-1:0] rt_q,
    output logic [RW-1:0] rd_q,
    output logic          ex_valid,
    output logic          stall,
    output logic [15:0]   bubble_cnt
);

    // Next-state values for every flop.
    logic [2:0]    AluOperation_d;
    logic          regDst_d;
    logic          regWrite_d;
    logic          AluSrc_d;
    logic          MemWrite_d;
    logic          MemRead_d;
    logic          DataSrc_d;
    logic [DW-1:0] readData1_d;
    logic [DW-1:0] readData2_d;
    logic [DW-1:0] imm_d;
    logic [RW-1:0] rs_d;
    logic [RW-1:0] rt_d;
    logic [RW-1:0] rd_d;
    logic          ex_valid_d;
    logic          ex_valid_q;
    logic [15:0]   bubble_cnt_d;
    logic [15:0]   bubble_cnt_q;

    logic          haz;
    logic          bubble;

    // A load in EX whose destination (rt) is a source of the decode
    // instruction cannot forward in time, so the consumer waits one cycle.
    // Register 0 is hard-wired to zero, so a load into it never creates a
    // dependency.
    always_comb begin
        haz = id_valid & ex_valid_q & MemRead_q & (rt_q != '0) &
              ((rt_q == rs_in) | (rt_q == rt_in));
        // A flush discards the decode instruction anyway, so holding it
        // upstream would be pointless.
        stall  = haz & ~flush;
        bubble = flush | haz;
    end

    // Next-state selection. By default every field holds its value. This is
    // what a flush or bubble needs for the data fields.
    always_comb begin
        AluOperation_d = AluOperation_q;
        regDst_d       = regDst_q;
        regWrite_d     = regWrite_q;
        AluSrc_d       = AluSrc_q;
        MemWrite_d     = MemWrite_q;
        MemRead_d      = MemRead_q;
        DataSrc_d      = DataSrc_q;
        readData1_d    = readData1_q;
        readData2_d    = readData2_q;
        imm_d          = imm_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        ex_valid_d     = ex_valid_q;

        if (bubble) begin
            // Clearing MemRead_q here guarantees the hazard drops next cycle,
            // so every load-use costs exactly one bubble.
            AluOperation_d = '0;
            regDst_d       = 1'b0;
            regWrite_d     = 1'b0;
            AluSrc_d       = 1'b0;
            MemWrite_d     = 1'b0;
            MemRead_d      = 1'b0;
            DataSrc_d      = 1'b0;
            ex_valid_d     = 1'b0;
        end else begin
            // Data is captured unconditionally. Control is gated by id_valid so
            // that an empty decode slot can never write a register or touch
            // memory.
            AluOperation_d = id_valid ? AluOperation_in : 3'b000;
            regDst_d       = id_valid & regDst_in;
            regWrite_d     = id_valid & regWrite_in;
            AluSrc_d       = id_valid & AluSrc_in;
            MemWrite_d     = id_valid & MemWrite_in;
            MemRead_d      = id_valid & MemRead_in;
            DataSrc_d      = id_valid & DataSrc_in;
            readData1_d    = readData1_in;
            readData2_d    = readData2_in;
            imm_d          = imm_in;
            rs_d           = rs_in;
            rt_d           = rt_in;
            rd_d           = rd_in;
            ex_valid_d     = id_valid;
        end
    end

    // Bubble counter saturates at all-ones so that long runs never wrap back to
    // a misleadingly small number. A flush coinciding with a hazard is one
    // bubble, not two.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Pipeline register state. Reset clears everything, including any pending
    // hazard. With ex_valid low, the first edge after reset is a plain load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AluOperation_q <= '0;
            regDst_q       <= 1'b0;
            regWrite_q     <= 1'b0;
            AluSrc_q       <= 1'b0;
            MemWrite_q     <= 1'b0;
            MemRead_q      <= 1'b0;
            DataSrc_q      <= 1'b0;
            readData1_q    <= '0;
            readData2_q    <= '0;
            imm_q          <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            ex_valid_q     <= 1'b0;
            bubble_cnt_q   <= '0;
        end else begin
            AluOperation_q <= AluOperation_d;
            regDst_q       <= regDst_d;
            regWrite_q     <= regWrite_d;
            AluSrc_q       <= AluSrc_d;
            MemWrite_q     <= MemWrite_d;
            MemRead_q      <= MemRead_d;
            DataSrc_q      <= DataSrc_d;
            readData1_q    <= readData1_d;
            readData2_q    <= readData2_d;
            imm_q          <= imm_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            ex_valid_q     <= ex_valid_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
